// File: rtl/lfsr_step_sequencer_if.sv
// ---------------------------------------------------------------------------
// lfsr_step_sequencer_if
//   Command/status bundle between the board top level, the external 8-bit
//   LFSR and lfsr_step_sequencer. Clock and reset are plain module ports.
//
//   Signals
//     START, STOP, STEP  command pulses towards the sequencer
//     COUNT              steps per run, sampled on START (0 = free-run)
//     LFSR_O             current external LFSR state, fed back in
//     CE                 LFSR step enable, one cycle per step
//     BUSY, DONE         run status / counted-run completion pulse
//     PERIOD, PERIOD_VALID  measured LFSR period (LFSR_WIDTH+1 bits)
//     LOCKUP             sticky lockup flag (only active with
//                        LFSR_SEQ_LOCKUP_DET_EN)
//
//   Modports
//     master  drives commands and LFSR_O, observes status
//     slave   the sequencer itself
// ---------------------------------------------------------------------------
interface lfsr_step_sequencer_if #(
  parameter int COUNT_WIDTH = 8,
  parameter int LFSR_WIDTH  = 8
);
  logic                   START;
  logic                   STOP;
  logic                   STEP;
  logic [COUNT_WIDTH-1:0] COUNT;
  logic [LFSR_WIDTH-1:0]  LFSR_O;
  logic                   CE;
  logic                   BUSY;
  logic                   DONE;
  logic [LFSR_WIDTH:0]    PERIOD;
  logic                   PERIOD_VALID;
  logic                   LOCKUP;

  modport master (
    output START, STOP, STEP, COUNT, LFSR_O,
    input  CE, BUSY, DONE, PERIOD, PERIOD_VALID, LOCKUP
  );

  modport slave (
    input  START, STOP, STEP, COUNT, LFSR_O,
    output CE, BUSY, DONE, PERIOD, PERIOD_VALID, LOCKUP
  );
endinterface

// File: rtl/lfsr_step_sequencer.sv
// ---------------------------------------------------------------------------
// lfsr_step_sequencer
//   Generates the CE step strobe for an external LFSR. A prescaler paces
//   steps to one every 2^PRESCALE_WIDTH cycles while running. Supports
//   counted runs, free-run (COUNT = 0), single steps and stop, and measures
//   the number of steps until the LFSR returns to its start value.
//
//   Ports
//     CLK    clock, all state on the rising edge
//     RESET  synchronous reset, active high
//     bus    lfsr_step_sequencer_if.slave (commands, LFSR_O feedback,
//            CE / BUSY / DONE / PERIOD / PERIOD_VALID / LOCKUP)
//
//   Build option
//     LFSR_SEQ_LOCKUP_DET_EN  when defined, a step that leaves LFSR_O
//       unchanged raises a sticky LOCKUP and ends the run without DONE.
//       When undefined, LOCKUP is tied low and no comparison is built.
//
//   Command priority each cycle: RESET > STOP > START > STEP.
// ---------------------------------------------------------------------------
module lfsr_step_sequencer #(
  parameter int PRESCALE_WIDTH = 22,
  parameter int COUNT_WIDTH    = 8,
  parameter int LFSR_WIDTH     = 8
) (
  input  logic                CLK,
  input  logic                RESET,
  lfsr_step_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    SINGLE = 2'd2
  } state_t;

  localparam logic [PRESCALE_WIDTH-1:0] PRESCALE_MAX = '1;
  localparam logic [PRESCALE_WIDTH-1:0] PRESCALE_ONE = {{(PRESCALE_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [COUNT_WIDTH-1:0]    COUNT_ONE    = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LFSR_WIDTH:0]       PERIOD_MAX   = '1;
  localparam logic [LFSR_WIDTH:0]       PERIOD_ONE   = {{LFSR_WIDTH{1'b0}}, 1'b1};

  state_t                    state;
  logic [PRESCALE_WIDTH-1:0] prescaler;
  logic [COUNT_WIDTH-1:0]    count_q;
  logic [COUNT_WIDTH-1:0]    step_cnt;
  logic [LFSR_WIDTH-1:0]     start_val;
  logic [LFSR_WIDTH:0]       period_cnt;
  logic [LFSR_WIDTH:0]       period_q;
  logic                      period_valid_q;
  logic                      period_chk_q;   // a RUN step happened last cycle
  logic                      done_q;

  logic start_cmd;
  logic hit_en;
  logic ce_run;
  logic ce;
  logic final_step;
  logic period_hit;
  logic lockup_hit;

  // START only counts when STOP is not also asserted.
  assign start_cmd = bus.START && !bus.STOP;

  // Post-step comparisons are ignored while a reset or restart is in progress.
  assign hit_en = !RESET && !start_cmd;

  // A restart suppresses the pending step so start_val is the state the new
  // run counts from; a detected lockup ends the run before another step.
  assign ce_run = (state == RUN) && (prescaler == PRESCALE_MAX) &&
                  !bus.STOP && !start_cmd && !lockup_hit;
  assign ce     = ce_run || (state == SINGLE);

  assign final_step = ce_run && (count_q != '0) && (step_cnt == count_q - COUNT_ONE);

  // The compare happens in the cycle after a step, once LFSR_O shows the new
  // state; the result is visible in that same cycle and latched for later.
  // A saturated counter no longer holds a true step count, so it never matches.
  assign period_hit = hit_en && period_chk_q && !period_valid_q &&
                      (bus.LFSR_O == start_val) && (period_cnt != PERIOD_MAX);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    // NOTE: reset is synchronous; it is just the highest-priority branch of
    // the clocked logic, with no entry in the sensitivity list.
    if (RESET) begin
      state          <= IDLE;
      prescaler      <= '0;
      count_q        <= '0;
      step_cnt       <= '0;
      start_val      <= '0;
      period_cnt     <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      period_chk_q   <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      done_q       <= 1'b0;
      period_chk_q <= 1'b0;

      if (bus.STOP) begin
        state <= IDLE;
      end else if (bus.START) begin
        state          <= RUN;
        count_q        <= bus.COUNT;
        start_val      <= bus.LFSR_O;
        prescaler      <= '0;
        step_cnt       <= '0;
        period_cnt     <= '0;
        period_q       <= '0;
        period_valid_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.STEP) state <= SINGLE;
          end
          RUN: begin
            prescaler <= prescaler + PRESCALE_ONE;
            if (lockup_hit) begin
              state <= IDLE;
            end else if (ce_run) begin
              step_cnt     <= step_cnt + COUNT_ONE;   // wraps silently in free-run
              period_chk_q <= 1'b1;
              if (period_cnt != PERIOD_MAX) period_cnt <= period_cnt + PERIOD_ONE;
              if (final_step) begin
                state  <= IDLE;
                done_q <= 1'b1;
              end
            end
          end
          SINGLE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end

      // First match only; period_hit is already masked during a restart.
      if (period_hit) begin
        period_q       <= period_cnt;
        period_valid_q <= 1'b1;
      end
    end
  end

`ifdef LFSR_SEQ_LOCKUP_DET_EN
  logic                  lockup_chk_q;   // any step happened last cycle
  logic [LFSR_WIDTH-1:0] pre_val;        // LFSR_O as it was when that step fired
  logic                  lockup_q;

  assign lockup_hit = hit_en && lockup_chk_q && (bus.LFSR_O == pre_val);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      lockup_chk_q <= 1'b0;
      pre_val      <= '0;
      lockup_q     <= 1'b0;
    end else begin
      lockup_chk_q <= ce;
      if (ce) pre_val <= bus.LFSR_O;
      if (start_cmd)       lockup_q <= 1'b0;
      else if (lockup_hit) lockup_q <= 1'b1;
    end
  end

  assign bus.LOCKUP = lockup_q || lockup_hit;
`else
  assign lockup_hit = 1'b0;
  assign bus.LOCKUP = 1'b0;
`endif

  // A lockup seen this cycle already ends the run as far as the outside sees.
  assign bus.CE           = ce;
  assign bus.BUSY         = (state != IDLE) && !lockup_hit;
  assign bus.DONE         = done_q && !lockup_hit;
  assign bus.PERIOD_VALID = period_valid_q || period_hit;
  assign bus.PERIOD       = period_hit ? period_cnt : period_q;

endmodule

// File: tb/tb_lfsr_step_sequencer.sv
`timescale 1ns/1ps
module tb_lfsr_step_sequencer;

  localparam int PW  = 2;
  localparam int CW  = 8;
  localparam int LW  = 8;
  localparam int GAP = 1 << PW;

  typedef struct packed {
    logic ce;
    logic busy;
    logic done;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  lfsr_step_sequencer_if #(.COUNT_WIDTH(CW), .LFSR_WIDTH(LW)) bus ();

  lfsr_step_sequencer #(
    .PRESCALE_WIDTH(PW),
    .COUNT_WIDTH   (CW),
    .LFSR_WIDTH    (LW)
  ) dut (
    .CLK  (clk),
    .RESET(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [LW-1:0] lfsr;        // the external LFSR register
  bit            hold_lfsr;   // freeze LFSR_O (lockup scenario)

  logic          obs_ce, obs_busy, obs_done, obs_pv, obs_lock;
  logic [LW:0]   obs_period;

  // Maximal-length 8-bit XNOR LFSR, taps 8,6,5,4; all-ones is its lockup state.
  function automatic logic [LW-1:0] lfsr_next(logic [LW-1:0] x);
    logic fb;
    fb = ~(x[7] ^ x[5] ^ x[4] ^ x[3]);
    return {x[6:0], fb};
  endfunction

  // Expected CE/BUSY/DONE for cycle k of a run started at cycle 0.
  // count = 0 is free-run; stop_at < 1 means no STOP.
  function automatic exp_t exp_run(int k, int count, int stop_at);
    exp_t e;
    int   last_ce;
    int   busy_end;
    bit   aborted;
    last_ce  = (count == 0) ? 32'h3fff_ffff : GAP * count;
    aborted  = (stop_at >= 1) && (stop_at <= last_ce);
    busy_end = aborted ? stop_at : last_ce;
    e.ce   = (k >= 1) && (k % GAP == 0) && (k <= last_ce) && !(aborted && k >= stop_at);
    e.busy = (k >= 1) && (k <= busy_end);
    e.done = !aborted && (count != 0) && (k == last_ce + 1);
    return e;
  endfunction

  // Inputs for the current cycle are already applied; sample, then advance.
  task automatic cycle();
    #3;
    obs_ce     = bus.CE;
    obs_busy   = bus.BUSY;
    obs_done   = bus.DONE;
    obs_pv     = bus.PERIOD_VALID;
    obs_lock   = bus.LOCKUP;
    obs_period = bus.PERIOD;
    @(posedge clk);
    #1;
    if (obs_ce === 1'b1) lfsr = lfsr_next(lfsr);
    if (!hold_lfsr) bus.LFSR_O = lfsr;
    bus.START = 1'b0;
    bus.STOP  = 1'b0;
    bus.STEP  = 1'b0;
  endtask

  task automatic test_reset();
    cycle();
    checks++;
    if ({obs_ce, obs_busy, obs_done, obs_pv, obs_lock} !== 5'b0 || obs_period !== '0) begin
      failures++;
      $display("FAIL reset_state ce/busy/done/pv/lock=%b period=%0d, expected all 0",
               {obs_ce, obs_busy, obs_done, obs_pv, obs_lock}, obs_period);
    end
  endtask

  task automatic test_counted_run();
    exp_t e;
    bus.COUNT = 8'd3;
    bus.START = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      cycle();
      e = exp_run(k, 3, -1);
      checks++;
      if ({obs_ce, obs_busy, obs_done} !== e) begin
        failures++;
        $display("FAIL counted_run k=%0d ce/busy/done=%b expected=%b",
                 k, {obs_ce, obs_busy, obs_done}, e);
      end
    end
  endtask

  task automatic test_single_step();
    exp_t e;
    bus.STEP = 1'b1;
    for (int k = 0; k <= 3; k++) begin
      cycle();
      e = '{ce: (k == 1), busy: (k == 1), done: 1'b0};
      checks++;
      if ({obs_ce, obs_busy, obs_done} !== e) begin
        failures++;
        $display("FAIL single_step k=%0d ce/busy/done=%b expected=%b",
                 k, {obs_ce, obs_busy, obs_done}, e);
      end
    end
  endtask

  task automatic test_stop();
    exp_t e;
    bus.COUNT = 8'd0;
    bus.START = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      if (k == 6) bus.STOP = 1'b1;
      cycle();
      e = exp_run(k, 0, 6);
      checks++;
      if ({obs_ce, obs_busy, obs_done} !== e) begin
        failures++;
        $display("FAIL stop_free_run k=%0d ce/busy/done=%b expected=%b",
                 k, {obs_ce, obs_busy, obs_done}, e);
      end
    end
    // START and STOP together: STOP wins, nothing runs.
    bus.COUNT = 8'd2;
    bus.START = 1'b1;
    bus.STOP  = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      cycle();
      checks++;
      if ({obs_ce, obs_busy, obs_done} !== 3'b000) begin
        failures++;
        $display("FAIL start_stop_same k=%0d ce/busy/done=%b expected=000",
                 k, {obs_ce, obs_busy, obs_done});
      end
    end
  endtask

  // Restart mid-run with a new COUNT; STEP pulses inside a run are ignored.
  task automatic test_back_to_back();
    exp_t e;
    bus.COUNT = 8'd4;
    bus.START = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      if (k == 2 || k == 9) bus.STEP = 1'b1;
      if (k == 6) begin
        bus.COUNT = 8'd2;
        bus.START = 1'b1;
      end
      cycle();
      if (k < 6)       e = exp_run(k, 4, -1);
      else if (k == 6) e = '{ce: 1'b0, busy: 1'b1, done: 1'b0};
      else             e = exp_run(k - 6, 2, -1);
      checks++;
      if ({obs_ce, obs_busy, obs_done} !== e) begin
        failures++;
        $display("FAIL back_to_back k=%0d ce/busy/done=%b expected=%b",
                 k, {obs_ce, obs_busy, obs_done}, e);
      end
    end
  endtask

  // Free-run until the LFSR wraps; leaves the sequencer running.
  task automatic test_period();
    exp_t          e;
    logic [LW-1:0] x;
    int            p;
    logic          exp_pv;
    logic [LW:0]   exp_per;
    x = lfsr;
    p = 0;
    do begin
      x = lfsr_next(x);
      p++;
    end while (x != lfsr && p < 600);

    bus.COUNT = 8'd0;
    bus.START = 1'b1;
    for (int k = 0; k <= GAP * p + 12; k++) begin
      cycle();
      e = exp_run(k, 0, -1);
      checks++;
      if ({obs_ce, obs_busy, obs_done} !== e) begin
        failures++;
        $display("FAIL period_run k=%0d ce/busy/done=%b expected=%b",
                 k, {obs_ce, obs_busy, obs_done}, e);
      end
      if (k >= 1) begin
        exp_pv  = (k >= GAP * p + 1);
        exp_per = exp_pv ? (LW+1)'(p) : '0;
        checks++;
        if (obs_pv !== exp_pv || obs_period !== exp_per) begin
          failures++;
          $display("FAIL period_value k=%0d valid=%b period=%0d expected valid=%b period=%0d",
                   k, obs_pv, obs_period, exp_pv, exp_per);
        end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    checks++;
    if ({obs_ce, obs_busy, obs_done, obs_pv, obs_lock} !== 5'b0 || obs_period !== '0) begin
      failures++;
      $display("FAIL reset_mid_run ce/busy/done/pv/lock=%b period=%0d, expected all 0",
               {obs_ce, obs_busy, obs_done, obs_pv, obs_lock}, obs_period);
    end
    for (int k = 0; k < 6; k++) begin
      cycle();
      checks++;
      if ({obs_ce, obs_busy} !== 2'b00) begin
        failures++;
        $display("FAIL reset_stays_idle k=%0d ce/busy=%b expected=00", k, {obs_ce, obs_busy});
      end
    end
  endtask

  task automatic test_lockup();
    exp_t e;
    logic exp_lock;
    hold_lfsr  = 1'b1;
    bus.LFSR_O = 8'h5A;
    bus.COUNT  = 8'd5;
    bus.START  = 1'b1;
    for (int k = 0; k <= 24; k++) begin
      cycle();
`ifdef LFSR_SEQ_LOCKUP_DET_EN
      e        = '{ce: (k == 4), busy: (k >= 1 && k <= 4), done: 1'b0};
      exp_lock = (k >= 5);
`else
      e        = exp_run(k, 5, -1);
      exp_lock = 1'b0;
`endif
      checks++;
      if ({obs_ce, obs_busy, obs_done, obs_lock} !== {e, exp_lock}) begin
        failures++;
        $display("FAIL lockup k=%0d ce/busy/done/lock=%b expected=%b",
                 k, {obs_ce, obs_busy, obs_done, obs_lock}, {e, exp_lock});
      end
    end
    hold_lfsr = 1'b0;
    cycle();
  endtask

  task automatic test_random_runs();
    exp_t e;
    int   cnt;
    int   stop_at;
    for (int r = 0; r < 10; r++) begin
      cnt     = $urandom_range(1, 5);
      stop_at = ($urandom_range(0, 1) == 1) ? $urandom_range(1, GAP * cnt + 2) : -1;
      bus.COUNT = CW'(cnt);
      bus.START = 1'b1;
      for (int k = 0; k <= GAP * cnt + 4; k++) begin
        if (k == stop_at) bus.STOP = 1'b1;
        e = exp_run(k, cnt, stop_at);
        if (e.busy && $urandom_range(0, 2) == 0) bus.STEP = 1'b1;
        cycle();
        checks++;
        if ({obs_ce, obs_busy, obs_done} !== e) begin
          failures++;
          $display("FAIL random_run r=%0d count=%0d stop=%0d k=%0d ce/busy/done=%b expected=%b",
                   r, cnt, stop_at, k, {obs_ce, obs_busy, obs_done}, e);
        end
        if (k >= 1) begin
          checks++;
          if ({obs_pv, obs_lock} !== 2'b00) begin
            failures++;
            $display("FAIL random_flags r=%0d k=%0d valid/lock=%b expected=00",
                     r, k, {obs_pv, obs_lock});
          end
        end
      end
    end
  endtask

  initial begin
    bus.START  = 1'b0;
    bus.STOP   = 1'b0;
    bus.STEP   = 1'b0;
    bus.COUNT  = '0;
    lfsr       = 8'h01;
    bus.LFSR_O = lfsr;
    hold_lfsr  = 1'b0;
    rst        = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    test_reset();
    test_counted_run();
    test_single_step();
    test_stop();
    test_back_to_back();
    test_period();
    test_reset_mid_run();
    test_lockup();
    test_random_runs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
